cmp_arbiter_ctrl: RTL

- Sequences the shared subtract ALU and the branch/compare comparison unit on behalf of two requesters: requester 0 is branch resolution, requester 1 is set-less-than/compare writeback.
- Arbitrates round-robin between the two, latches the operands and issues a subtract to the shared ALU.
- Captures the ALU flags, drives the comparison unit and returns a 1-bit result to the granted requester through a valid/ready response channel.

---
 rtl/cmp_arbiter_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/cmp_arbiter_ctrl.sv
// Round-robin sequencer giving two requesters shared use of a subtract ALU and a compare unit.
// Latency: RESP is entered ALU_LAT+2 edges after the accept edge; one transaction per ALU_LAT+4 cycles.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready, with no accept in the handshake cycle.
module cmp_arbiter_ctrl #(
   parameter int ALU_LAT = 1,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [2:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [2:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic             alu_start,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_diff,
   output logic             cmp_a31,
   output logic             cmp_b31,
   output logic             cmp_carry,
   output logic             cmp_zero,
   output logic             cmp_diff,
   output logic [2:0]       cmp_op,
   input  logic             cmp_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_result,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal
);

   localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_RESOLVE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             id_q, id_d;
   logic             cmp_a31_q, cmp_a31_d;
   logic             cmp_b31_q, cmp_b31_d;
   logic             cmp_carry_q, cmp_carry_d;
   logic             cmp_zero_q, cmp_zero_d;
   logic             cmp_diff_q, cmp_diff_d;
   logic [2:0]       cmp_op_q, cmp_op_d;
   logic             rsp_result_q, rsp_result_d;
   logic             rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_illegal_q, rsp_illegal_d;

   logic             gnt_vld;
   logic             gnt_id;
   logic             op_legal;

   // Grant: pointer-preferred requester first, otherwise whichever one is valid.
   // req_ready is gated by rst_n so it reads 0 throughout reset even if req_valid is high.
   always_comb begin
      gnt_vld   = |req_valid;
      gnt_id    = req_valid[ptr_q] ? ptr_q : ~ptr_q;
      req_ready = '0;
      if (rst_n && (state_q == S_IDLE) && gnt_vld) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   // The five encodings the compare unit understands; anything else is reported as illegal.
   always_comb begin
      case (op_q)
         3'b001, 3'b011, 3'b100, 3'b101, 3'b110: op_legal = 1'b1;
         default:                                op_legal = 1'b0;
      endcase
   end

   // Next-state and datapath capture for the IDLE-ISSUE-WAIT-RESOLVE-RESP sequence.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      tag_d         = tag_q;
      id_d          = id_q;
      cmp_a31_d     = cmp_a31_q;
      cmp_b31_d     = cmp_b31_q;
      cmp_carry_d   = cmp_carry_q;
      cmp_zero_d    = cmp_zero_q;
      cmp_diff_d    = cmp_diff_q;
      cmp_op_d      = cmp_op_q;
      rsp_result_d  = rsp_result_q;
      rsp_id_d      = rsp_id_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               a_d     = gnt_id ? req1_a   : req0_a;
               b_d     = gnt_id ? req1_b   : req0_b;
               op_d    = gnt_id ? req1_op  : req0_op;
               tag_d   = gnt_id ? req1_tag : req0_tag;
               id_d    = gnt_id;
               ptr_d   = ~gnt_id;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Flags are only trusted on the edge that leaves WAIT.
            if (cnt_q == '0) begin
               cmp_carry_d = alu_carry;
               cmp_zero_d  = alu_zero;
               cmp_diff_d  = alu_diff;
               cmp_a31_d   = a_q[31];
               cmp_b31_d   = b_q[31];
               cmp_op_d    = op_q;
               state_d     = S_RESOLVE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESOLVE: begin
            rsp_illegal_d = ~op_legal;
            rsp_result_d  = op_legal & cmp_out;
            rsp_id_d      = id_q;
            rsp_tag_d     = tag_q;
            state_d       = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= 1'b0;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         tag_q         <= '0;
         id_q          <= 1'b0;
         cmp_a31_q     <= 1'b0;
         cmp_b31_q     <= 1'b0;
         cmp_carry_q   <= 1'b0;
         cmp_zero_q    <= 1'b0;
         cmp_diff_q    <= 1'b0;
         cmp_op_q      <= '0;
         rsp_result_q  <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_tag_q     <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         tag_q         <= tag_d;
         id_q          <= id_d;
         cmp_a31_q     <= cmp_a31_d;
         cmp_b31_q     <= cmp_b31_d;
         cmp_carry_q   <= cmp_carry_d;
         cmp_zero_q    <= cmp_zero_d;
         cmp_diff_q    <= cmp_diff_d;
         cmp_op_q      <= cmp_op_d;
         rsp_result_q  <= rsp_result_d;
         rsp_id_q      <= rsp_id_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_start   = (state_q == S_ISSUE);
   assign cmp_a31     = cmp_a31_q;
   assign cmp_b31     = cmp_b31_q;
   assign cmp_carry   = cmp_carry_q;
   assign cmp_zero    = cmp_zero_q;
   assign cmp_diff    = cmp_diff_q;
   assign cmp_op      = cmp_op_q;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_result  = rsp_result_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_illegal = rsp_illegal_q;

endmodule
